// File: rtl/hazard_ctrl_pkg.sv
// Shared MIPS pipeline constants: forwarding selects, mult/div sequencer states, and the register-0 rule.
package mips_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned STAT_W = 32;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // A producer matches a consumer only on a real (non-$zero) register.
  function automatic logic reg_hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if;
  import mips_pkg::*;

  logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_W-1:0] write_reg_e, write_reg_m, write_reg_w;
  logic             reg_write_e, reg_write_m, reg_write_w;
  logic             mem_to_reg_e, mem_to_reg_m;
  logic             branch_d, jump_d, pc_src_d, hilo_read_d;
  logic             md_start_e, md_div_e;
  logic             stall_f, stall_d, clr_d, flush_e;
  logic             fwd_a_d, fwd_b_d;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             md_busy, hilo_we;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, jump_d, pc_src_d, hilo_read_d, md_start_e, md_div_e,
    input  stall_f, stall_d, clr_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
           md_busy, hilo_we
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, jump_d, pc_src_d, hilo_read_d, md_start_e, md_div_e,
    output stall_f, stall_d, clr_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e,
           md_busy, hilo_we
  );
endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Mult/div sequencer: counts HI/LO busy cycles on negedge clk and pulses hilo_we on completion.
module md_seq
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_e,
  input  logic md_div_e,
  output logic md_busy,
  output logic hilo_we
);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, load;

  assign load = md_div_e ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      hilo_we <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      md_busy <= (state_n != IDLE);
      hilo_we <= (state_n == DONE);
    end
  end

  // A held start while BUSY or DONE is the same instruction, so only IDLE accepts it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (md_start_e) begin
          if (load == '0) begin
            state_n = DONE;
          end else begin
            state_n = BUSY;
            cnt_n   = load;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, stall/flush and forwarding control for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  logic md_busy, hilo_we;
  logic lwstall, brstall, mdstall, stall;
  logic e_hit_d, m_hit_d;

  md_seq #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .md_start_e(hz.md_start_e),
    .md_div_e  (hz.md_div_e),
    .md_busy   (md_busy),
    .hilo_we   (hilo_we)
  );

  always_comb begin
    e_hit_d = reg_hit(hz.write_reg_e, hz.rs_d) | reg_hit(hz.write_reg_e, hz.rt_d);
    m_hit_d = reg_hit(hz.write_reg_m, hz.rs_d) | reg_hit(hz.write_reg_m, hz.rt_d);
    lwstall = hz.mem_to_reg_e & hz.reg_write_e & e_hit_d;
    brstall = hz.branch_d & ((hz.reg_write_e & e_hit_d) | (hz.mem_to_reg_m & m_hit_d));
    mdstall = (md_busy & (hz.hilo_read_d | hz.md_start_e)) |
              (~md_busy & hz.md_start_e & hz.hilo_read_d);
    stall   = lwstall | brstall | mdstall;
  end

  // Memory stage wins over writeback when both produce the same register.
  function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] src);
    if (hz.reg_write_m && reg_hit(hz.write_reg_m, src)) return FWD_MEM;
    if (hz.reg_write_w && reg_hit(hz.write_reg_w, src)) return FWD_WB;
    return FWD_RF;
  endfunction

  // Everything is forced quiet while reset is held.
  assign hz.stall_f = ~rst & stall;
  assign hz.stall_d = ~rst & stall;
  assign hz.flush_e = ~rst & (lwstall | brstall);
  assign hz.clr_d   = ~rst & (hz.pc_src_d | hz.jump_d) & ~stall;
  assign hz.fwd_a_d = ~rst & hz.reg_write_m & reg_hit(hz.write_reg_m, hz.rs_d);
  assign hz.fwd_b_d = ~rst & hz.reg_write_m & reg_hit(hz.write_reg_m, hz.rt_d);
  assign hz.fwd_a_e = rst ? FWD_RF : fwd_e(hz.rs_e);
  assign hz.fwd_b_e = rst ? FWD_RF : fwd_e(hz.rt_e);
  assign hz.md_busy = md_busy;
  assign hz.hilo_we = hilo_we;

`ifdef HAZARD_STATS_EN
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.stall_d && (stall_cnt != '1)) stall_cnt <= stall_cnt + STAT_W'(1);
      if ((hz.clr_d || hz.flush_e) && (flush_cnt != '1)) flush_cnt <= flush_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed test-plan steps plus random cycles against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  longint m_stall_cnt, m_flush_cnt;
`else
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));
`endif

  int nvec = 0;
  int nerr = 0;
  int rem  = 0;
  bit e_stall, e_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [4:0] d, input logic [4:0] s);
    return (d != 5'd0) && (d == s);
  endfunction

  function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
    if (hz.reg_write_m && hit(hz.write_reg_m, src)) return 2'b10;
    if (hz.reg_write_w && hit(hz.write_reg_w, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    {hz.rs_d, hz.rt_d, hz.rs_e, hz.rt_e} = '0;
    {hz.write_reg_e, hz.write_reg_m, hz.write_reg_w} = '0;
    {hz.reg_write_e, hz.reg_write_m, hz.reg_write_w} = '0;
    {hz.mem_to_reg_e, hz.mem_to_reg_m, hz.branch_d, hz.jump_d} = '0;
    {hz.pc_src_d, hz.hilo_read_d, hz.md_start_e, hz.md_div_e} = '0;
  endtask

  // Expected outputs follow directly from the hazard rules and the remaining busy-cycle count.
  task automatic check_all();
    bit lw, br, md, eh, mh, busy;
    nvec++;
    busy = (rem > 0);
    eh = hit(hz.write_reg_e, hz.rs_d) || hit(hz.write_reg_e, hz.rt_d);
    mh = hit(hz.write_reg_m, hz.rs_d) || hit(hz.write_reg_m, hz.rt_d);
    lw = hz.mem_to_reg_e && hz.reg_write_e && eh;
    br = hz.branch_d && ((hz.reg_write_e && eh) || (hz.mem_to_reg_m && mh));
    md = busy ? (hz.hilo_read_d || hz.md_start_e) : (hz.md_start_e && hz.hilo_read_d);
    e_stall = !rst && (lw || br || md);
    e_flush = !rst && (((hz.pc_src_d || hz.jump_d) && !(lw || br || md)) || lw || br);
    check("stall_f", 32'(hz.stall_f), 32'(e_stall));
    check("stall_d", 32'(hz.stall_d), 32'(e_stall));
    check("flush_e", 32'(hz.flush_e), 32'(!rst && (lw || br)));
    check("clr_d", 32'(hz.clr_d), 32'(!rst && (hz.pc_src_d || hz.jump_d) && !(lw || br || md)));
    check("fwd_a_d", 32'(hz.fwd_a_d), 32'(!rst && hz.reg_write_m && hit(hz.write_reg_m, hz.rs_d)));
    check("fwd_b_d", 32'(hz.fwd_b_d), 32'(!rst && hz.reg_write_m && hit(hz.write_reg_m, hz.rt_d)));
    check("fwd_a_e", 32'(hz.fwd_a_e), rst ? 32'd0 : 32'(exp_fwd_e(hz.rs_e)));
    check("fwd_b_e", 32'(hz.fwd_b_e), rst ? 32'd0 : 32'(exp_fwd_e(hz.rt_e)));
    check("md_busy", 32'(hz.md_busy), 32'(busy));
    check("hilo_we", 32'(hz.hilo_we), 32'(rem == 1));
`ifdef HAZARD_STATS_EN
    check("stall_cnt", stall_cnt, 32'(m_stall_cnt));
    check("flush_cnt", flush_cnt, 32'(m_flush_cnt));
`endif
  endtask

  // Advance the reference model across the negedge, then return at the next posedge.
  task automatic advance();
    @(negedge clk);
    if (rst) rem = 0;
    else if (rem > 0) rem--;
    else if (hz.md_start_e) rem = hz.md_div_e ? DIV_N : MULT_N;
`ifdef HAZARD_STATS_EN
    if (rst) begin m_stall_cnt = 0; m_flush_cnt = 0; end
    else begin
      if (e_stall) m_stall_cnt++;
      if (e_flush) m_flush_cnt++;
    end
`endif
    @(posedge clk);
  endtask

  task automatic step();
    #1 check_all();
    advance();
  endtask

  task automatic rand_inputs();
    hz.rs_d = 5'($urandom_range(0, 3));  hz.rt_d = 5'($urandom_range(0, 3));
    hz.rs_e = 5'($urandom_range(0, 3));  hz.rt_e = 5'($urandom_range(0, 3));
    hz.write_reg_e = 5'($urandom_range(0, 3));
    hz.write_reg_m = 5'($urandom_range(0, 3));
    hz.write_reg_w = 5'($urandom_range(0, 3));
    hz.reg_write_e = 1'($urandom);  hz.reg_write_m = 1'($urandom);
    hz.reg_write_w = 1'($urandom);
    hz.mem_to_reg_e = 1'($urandom); hz.mem_to_reg_m = 1'($urandom);
    hz.branch_d = 1'($urandom);     hz.jump_d = ($urandom_range(0, 3) == 0);
    hz.pc_src_d = ($urandom_range(0, 3) == 0);
    hz.hilo_read_d = ($urandom_range(0, 3) == 0);
    hz.md_start_e = ($urandom_range(0, 11) == 0);
    hz.md_div_e = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
`ifdef HAZARD_STATS_EN
    m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all();
    check("rst_busy", 32'(hz.md_busy), 32'd0);
    advance();
    rst = 1'b0;

    // lw $t0 in execute, dependent add in decode
    hz.mem_to_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd8; hz.rs_d = 5'd8;
    #1 check_all();
    check("lw_stall", 32'({hz.stall_f, hz.stall_d, hz.flush_e}), 32'b111);
    advance();
    clear_inputs();
    hz.mem_to_reg_m = 1'b1; hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd8; hz.rs_d = 5'd8;
    #1 check_all();
    check("lw_m_nostall", 32'(hz.stall_d), 32'd0);
    check("lw_m_fwd_e", 32'(hz.fwd_a_e), 32'd0);
    advance();
    clear_inputs();
    hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd8; hz.rs_e = 5'd8;
    #1 check_all();
    check("lw_wb_fwd", 32'(hz.fwd_a_e), 32'b01);
    advance();

    // memory stage has priority; $zero never forwards
    clear_inputs();
    hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd9; hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd9;
    hz.rs_e = 5'd9;
    #1 check_all();
    check("fwd_mem_prio", 32'(hz.fwd_a_e), 32'b10);
    hz.rs_e = 5'd0; hz.write_reg_m = 5'd0; hz.write_reg_w = 5'd0;
    #1 check_all();
    check("fwd_zero", 32'(hz.fwd_a_e), 32'b00);
    advance();

    // beq dependent on execute result; stall beats redirect
    clear_inputs();
    hz.branch_d = 1'b1; hz.rt_d = 5'd5; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd5;
    hz.pc_src_d = 1'b1;
    #1 check_all();
    check("br_stall", 32'({hz.stall_d, hz.flush_e, hz.clr_d}), 32'b110);
    advance();

    // jump with no hazards
    clear_inputs();
    hz.jump_d = 1'b1;
    #1 check_all();
    check("jump_clr", 32'({hz.clr_d, hz.stall_d}), 32'b10);
    advance();

    // mult followed by mfhi: 4 stalled cycles, commit pulse in the fourth
    clear_inputs();
    hz.md_start_e = 1'b1;
    #1 check_all();
    check("mult_c0_stall", 32'(hz.stall_d), 32'd0);
    advance();
    hz.hilo_read_d = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) hz.md_start_e = 1'b0;
      #1 check_all();
      check("mult_stall", 32'(hz.stall_d), 32'(c <= 4));
      check("mult_hilo_we", 32'(hz.hilo_we), 32'(c == 4));
      check("mult_busy", 32'(hz.md_busy), 32'(c <= 4));
      advance();
    end

    // div aborted by reset mid-operation
    clear_inputs();
    hz.md_start_e = 1'b1; hz.md_div_e = 1'b1;
    for (int c = 0; c < 10; c++) step();
    hz.jump_d = 1'b1; hz.hilo_read_d = 1'b1;
    #2 rst = 1'b1;
    rem = 0;
    #1 check_all();
    check("abort_busy", 32'({hz.md_busy, hz.hilo_we, hz.stall_d, hz.clr_d}), 32'd0);
    advance();
    step();
    clear_inputs();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
